led_matrix_scan: RTL

Parametrised, time-multiplexed driver for a ROWS x COLS LED dot matrix (default 7 rows x 5 columns). It holds a double-buffered frame: single-pixel writes and clears go into a shadow buffer, and a swap request commits the shadow to the displayed buffer at the next frame boundary. It then scans the displayed buffer one row at a time, driving a one-hot row strobe and the matching column pattern. It replaces per-LED combinational demultiplexing and sits between the character/pattern logic and the matrix pins.

---
 rtl/led_matrix_pkg.sv | 19 +
 rtl/led_matrix_scan_if.sv | 33 +++
 rtl/led_scan_timer.sv | 51 +++++
 rtl/led_matrix_scan.sv | 96 +++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants, types and helpers for the LED matrix scan driver.
package led_matrix_pkg;

  localparam int unsigned DefRows = 7;
  localparam int unsigned DefCols = 5;
  localparam int unsigned DefDiv  = 1000;
  localparam int unsigned MaxRows = 16;

  typedef logic [DefCols-1:0] row_vec_t;

  // Row strobe for a row index; callers truncate to their own ROWS width.
  function automatic logic [MaxRows-1:0] onehot(input logic [3:0] row_idx);
    logic [MaxRows-1:0] vec;
    vec          = '0;
    vec[row_idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Pixel-write, swap and matrix-pin signals of the LED matrix scan driver.
interface led_matrix_scan_if
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned COLS = DefCols
);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);

  logic            EN;
  logic            WR_EN;
  logic [RowW-1:0] WR_ROW;
  logic [ColW-1:0] WR_COL;
  logic            WR_DATA;
  logic            CLR;
  logic            SWAP;
  logic            SWAP_PEND;
  logic [ROWS-1:0] ROW_OUT;
  logic [COLS-1:0] COL_OUT;
  logic            FRAME_START;

  modport master (
    output EN, WR_EN, WR_ROW, WR_COL, WR_DATA, CLR, SWAP,
    input  SWAP_PEND, ROW_OUT, COL_OUT, FRAME_START
  );

  modport slave (
    input  EN, WR_EN, WR_ROW, WR_COL, WR_DATA, CLR, SWAP,
    output SWAP_PEND, ROW_OUT, COL_OUT, FRAME_START
  );

endinterface

// File: rtl/led_scan_timer.sv
// Row dwell divider and row index counter; both hold while the scan is disabled.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned DIV  = DefDiv,
  localparam int unsigned RowW = $clog2(ROWS),
  localparam int unsigned DivW = $clog2(DIV)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [RowW-1:0] row_idx_o,
  output logic            row_start_o,
  output logic            frame_end_o
);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [RowW-1:0] row_idx_q, row_idx_d;
  logic            div_wrap, row_wrap;

  always_comb begin
    div_wrap  = (div_cnt_q == DivW'(DIV - 1));
    row_wrap  = (row_idx_q == RowW'(ROWS - 1));
    div_cnt_d = div_cnt_q;
    row_idx_d = row_idx_q;
    if (en_i) begin
      if (div_wrap) begin
        div_cnt_d = '0;
        row_idx_d = row_wrap ? '0 : row_idx_q + RowW'(1);
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      row_idx_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      row_idx_q <= row_idx_d;
    end
  end

  assign row_idx_o   = row_idx_q;
  assign row_start_o = (div_cnt_q == '0);
  assign frame_end_o = div_wrap && row_wrap;

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered, time-multiplexed LED matrix driver: shadow writes, frame-boundary
// commit, and registered one-hot row strobe with a blank cycle at each row start.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned COLS = DefCols,
  parameter int unsigned DIV  = DefDiv
) (
  input logic              CLK,
  input logic              RST,
  led_matrix_scan_if.slave bus
);

  localparam int unsigned RowW = $clog2(ROWS);

  logic [RowW-1:0] row_idx;
  logic            row_start;
  logic            frame_end;
  logic            commit;

  logic [COLS-1:0] shadow_q  [ROWS];
  logic [COLS-1:0] shadow_d  [ROWS];
  logic [COLS-1:0] display_q [ROWS];
  logic [COLS-1:0] display_d [ROWS];
  logic            swap_pend_q, swap_pend_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [COLS-1:0] col_out_q, col_out_d;
  logic            frame_start_q, frame_start_d;

  led_scan_timer #(
    .ROWS (ROWS),
    .DIV  (DIV)
  ) u_timer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (bus.EN),
    .row_idx_o   (row_idx),
    .row_start_o (row_start),
    .frame_end_o (frame_end)
  );

  always_comb begin
    commit = swap_pend_q && bus.EN && frame_end;

    shadow_d = shadow_q;
    if (bus.CLR) begin
      for (int r = 0; r < ROWS; r++) shadow_d[r] = '0;
    end else if (bus.WR_EN && (32'(bus.WR_ROW) < ROWS) && (32'(bus.WR_COL) < COLS)) begin
      shadow_d[bus.WR_ROW][bus.WR_COL] = bus.WR_DATA;
    end

    // Commit takes the pre-edge shadow, so a same-edge write waits for the next swap.
    display_d = display_q;
    if (commit) display_d = shadow_q;

    swap_pend_d = swap_pend_q;
    if (commit)        swap_pend_d = bus.SWAP;
    else if (bus.SWAP) swap_pend_d = 1'b1;

    row_out_d = '0;
    col_out_d = '0;
    if (bus.EN && !row_start) begin
      row_out_d = ROWS'(onehot(4'(row_idx)));
      col_out_d = display_q[row_idx];
    end

    frame_start_d = bus.EN && row_start && (row_idx == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < ROWS; r++) begin
        shadow_q[r]  <= '0;
        display_q[r] <= '0;
      end
      swap_pend_q   <= 1'b0;
      row_out_q     <= '0;
      col_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      swap_pend_q   <= swap_pend_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.SWAP_PEND   = swap_pend_q;
  assign bus.ROW_OUT     = row_out_q;
  assign bus.COL_OUT     = col_out_q;
  assign bus.FRAME_START = frame_start_q;

endmodule
